// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Turns a framed host byte stream into byte writes to the
//                big-endian instruction memory, holding the CPU until a frame
//                loads cleanly and then publishing its boot PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int         MEM_BYTES = 16384,
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [31:0]       boot_pc
);

    localparam logic [3:0] c_st_idle    = 4'd0;
    localparam logic [3:0] c_st_addr_hi = 4'd1;
    localparam logic [3:0] c_st_addr_lo = 4'd2;
    localparam logic [3:0] c_st_cnt_hi  = 4'd3;
    localparam logic [3:0] c_st_cnt_lo  = 4'd4;
    localparam logic [3:0] c_st_data    = 4'd5;
    localparam logic [3:0] c_st_csum    = 4'd6;
    localparam logic [3:0] c_st_done    = 4'd7;
    localparam logic [3:0] c_st_err     = 4'd8;

    localparam logic [18:0] c_mem_limit = 19'(MEM_BYTES);

    logic [3:0]        r_state;
    logic [7:0]        r_addr_hi;
    logic [15:0]       r_frame_addr;
    logic [7:0]        r_cnt_hi;
    logic [17:0]       r_left;
    logic [ADDR_W-1:0] r_wptr;
    logic [7:0]        r_csum;

    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;
    logic [31:0]       r_boot_pc;

    logic              w_hs;
    logic              w_sync;
    logic [15:0]       w_cnt;
    logic [18:0]       w_end;
    logic              w_bad;

    assign w_hs   = in_valid && r_in_ready;
    assign w_sync = (in_data == SYNC_BYTE);
    assign w_cnt  = {r_cnt_hi, in_data};

    // End address is computed wide enough that ADDR + 4*CNT can never wrap.
    assign w_end = {3'b000, r_frame_addr} + {1'b0, w_cnt, 2'b00};
    assign w_bad = (r_frame_addr[1:0] != 2'b00) || (w_end > c_mem_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_addr_hi    <= 8'h00;
            r_frame_addr <= 16'h0000;
            r_cnt_hi     <= 8'h00;
            r_left       <= 18'd0;
            r_wptr       <= '0;
            r_csum       <= 8'h00;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_boot_pc    <= 32'h0000_0000;
        end else begin
            r_in_ready <= 1'b1;
            r_mem_we   <= 1'b0;
            if (w_hs) begin
                case (r_state)
                    c_st_idle, c_st_done, c_st_err: begin
                        // Non-sync bytes between frames are dropped silently.
                        if (w_sync) begin
                            r_state    <= c_st_addr_hi;
                            r_cpu_hold <= 1'b1;
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_csum     <= 8'h00;
                        end
                    end
                    c_st_addr_hi: begin
                        r_addr_hi <= in_data;
                        r_state   <= c_st_addr_lo;
                    end
                    c_st_addr_lo: begin
                        r_frame_addr <= {r_addr_hi, in_data};
                        r_state      <= c_st_cnt_hi;
                    end
                    c_st_cnt_hi: begin
                        r_cnt_hi <= in_data;
                        r_state  <= c_st_cnt_lo;
                    end
                    c_st_cnt_lo: begin
                        r_left <= {w_cnt, 2'b00};
                        r_wptr <= r_frame_addr[ADDR_W-1:0];
                        if (w_bad) begin
                            r_state <= c_st_err;
                            r_error <= 1'b1;
                        end else if (w_cnt == 16'h0000) begin
                            r_state <= c_st_csum;
                        end else begin
                            r_state <= c_st_data;
                        end
                    end
                    c_st_data: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wptr;
                        r_mem_wdata <= in_data;
                        r_wptr      <= r_wptr + 1'b1;
                        r_csum      <= r_csum ^ in_data;
                        r_left      <= r_left - 18'd1;
                        if (r_left == 18'd1) begin
                            r_state <= c_st_csum;
                        end
                    end
                    c_st_csum: begin
                        if (in_data == r_csum) begin
                            r_state    <= c_st_done;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                            r_boot_pc  <= {16'h0000, r_frame_addr};
                        end else begin
                            r_state <= c_st_err;
                            r_error <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;
    assign boot_pc   = r_boot_pc;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_loader
//  Description : Directed frames for imem_boot_loader; expected writes are
//                queued at each handshake and matched by a write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        int cyc;
        int addr;
        int data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] boot_pc;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    imem_boot_loader #(
        .MEM_BYTES(16384),
        .ADDR_W   (14),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .boot_pc  (boot_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest queued write,
    // including the cycle it was due in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", mem_addr, mem_wdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(mem_addr) != e.addr || int'(mem_wdata) != e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic d, input logic e,
                              input logic h, input logic [31:0] pc);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_error"}, {31'd0, error}, {31'd0, e});
        chk({name, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
        chk({name, "_boot_pc"}, boot_pc, pc);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_wr, input int waddr);
        exp_t e;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        if (exp_wr) begin
            e.cyc  = cyc;
            e.addr = waddr;
            e.data = int'(b);
            exp_q.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bytes_t f, input int base, input int nwr, input int gap);
        for (int i = 0; i < f.size(); i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            send_byte(f[i], (i >= 5) && (i < 5 + nwr), base + i - 5);
            if (i == 0) begin
                chk("sync_cpu_hold", {31'd0, cpu_hold}, 32'd1);
                chk("sync_done_clr", {31'd0, done}, 32'd0);
                chk("sync_error_clr", {31'd0, error}, 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_rise", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t good100, bad_csum, good200, zero_cnt;
        good100  = '{8'hA5, 8'h00, 8'h64, 8'h00, 8'h02, 8'h48, 8'h08, 8'h00, 8'h00,
                     8'h48, 8'h09, 8'h00, 8'h04, 8'h05};
        bad_csum = good100;
        bad_csum[13] = 8'h06;
        good200  = '{8'hA5, 8'h00, 8'hC8, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        zero_cnt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        do_reset();

        send_frame(good100, 100, 8, 0);
        chk_status("good", 1'b1, 1'b0, 1'b0, 32'd100);
        chk_drained("good");

        do_reset();
        send_frame(bad_csum, 100, 8, 0);
        chk_status("bad_csum", 1'b0, 1'b1, 1'b1, 32'd0);
        chk_drained("bad_csum");

        send_frame('{8'hA5, 8'h00, 8'h65, 8'h00, 8'h01}, 0, 0, 0);
        chk_status("misaligned", 1'b0, 1'b1, 1'b1, 32'd0);
        repeat (2) @(negedge clk);
        chk_drained("misaligned");

        send_frame('{8'hA5, 8'h3F, 8'hFC, 8'h00, 8'h02}, 0, 0, 0);
        chk_status("overflow", 1'b0, 1'b1, 1'b1, 32'd0);
        repeat (2) @(negedge clk);
        chk_drained("overflow");

        send_frame('{8'hA5, 8'h3F, 8'hFC, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44},
                   16380, 4, 0);
        chk_status("top_fit", 1'b1, 1'b0, 1'b0, 32'd16380);
        chk_drained("top_fit");

        send_byte(8'h00, 1'b0, 0);
        send_byte(8'hFF, 1'b0, 0);
        send_byte(8'h5A, 1'b0, 0);
        chk_status("garbage", 1'b1, 1'b0, 1'b0, 32'd16380);
        send_frame(good100, 100, 8, 0);
        chk_status("after_garbage", 1'b1, 1'b0, 1'b0, 32'd100);
        chk_drained("after_garbage");

        send_frame(good200, 200, 4, 0);
        chk_status("reload200", 1'b1, 1'b0, 1'b0, 32'd200);
        chk_drained("reload200");

        send_frame(good100, 100, 8, 3);
        chk_status("stalled", 1'b1, 1'b0, 1'b0, 32'd100);
        chk_drained("stalled");

        send_frame(zero_cnt, 0, 0, 0);
        chk_status("zero_cnt", 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        chk_drained("zero_cnt");

        // Abort after three payload bytes; the fourth byte is offered on the reset edge.
        for (int i = 0; i < 8; i++) send_byte(good100[i], i >= 5, 100 + i - 5);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = good100[8];
        @(negedge clk);
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        chk_status("midrst", 1'b0, 1'b0, 1'b1, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_drained("midrst");
        @(negedge clk);
        send_frame(good100, 100, 8, 0);
        chk_status("after_midrst", 1'b1, 1'b0, 1'b0, 32'd100);
        chk_drained("after_midrst");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Writer side of the byte-addressed, big-endian instruction memory.
- Receives a framed byte stream from the host or debug link and writes the program image into the instruction memory's byte write port.
- Holds the pipeline off while loading and publishes the boot PC.
- Sits between the host link and the instruction memory; fetch continues to read {mem[PC],mem[PC+1],mem[PC+2],mem[PC+3]}.

Parameters:
- MEM_BYTES, 16384, instruction memory size in bytes.
- ADDR_W, 14, byte address width of the memory write port; log2(MEM_BYTES).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts byte; transfer when in_valid && in_ready.
- mem_we  output  1  one-cycle byte write strobe to instruction memory.
- mem_addr  output  ADDR_W  byte write address.
- mem_wdata  output  8  byte write data.
- cpu_hold  output  1  keeps the pipeline stalled and the PC reset while high.
- done  output  1  last frame loaded successfully.
- error  output  1  last frame rejected.
- boot_pc  output  32  start address of last successful frame, zero-extended.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, boot_pc=0, state=IDLE, checksum=0. in_ready goes to 1 the cycle after reset deasserts.
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, 4*CNT payload bytes, CSUM.
  - ADDR is a 16-bit byte address. CNT is a 16-bit word count.
  - Payload is stored big-endian: the first byte of each word goes to the lowest address.
  - CSUM = XOR of all payload bytes; 0x00 when CNT=0.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR. Each state advances only on a handshake; in_valid gaps are legal anywhere.
- IDLE/DONE/ERR: a byte equal to SYNC_BYTE goes to ADDR_HI and sets cpu_hold=1, done=0, error=0, checksum=0. Any other byte is consumed and discarded; state and outputs are unchanged.
- After CNT_LO, the frame is checked combinationally on the handshake. ERR if either:
  - ADDR[1:0]!=0; or
  - ADDR+4*CNT > MEM_BYTES, evaluated in 19-bit unsigned arithmetic with no wrap.
  - Otherwise go to DATA, or to CSUM when CNT=0.
- DATA, per accepted byte: on the next cycle mem_we=1, mem_addr=current address, mem_wdata=byte. The address increments by 1 and checksum ^= byte. After byte 4*CNT, go to CSUM.
- Write latency is exactly 1 cycle from handshake; at most one write per cycle.
- CSUM: if the byte matches the checksum, go to DONE; otherwise go to ERR.
  - DONE, registered on the same edge: done=1, cpu_hold=0, boot_pc=ADDR.
  - ERR: error=1, cpu_hold stays 1, boot_pc unchanged.
- Bytes already written by a rejected frame are not rolled back.
- in_ready=1 in every state after reset. The loader never backpressures.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values on that edge. A pending mem_we does not fire.
- SYNC_BYTE inside a payload is treated as data; there is no resync mid-frame.

Test Plan:
- Good load: A5 00 64 00 02 48 08 00 00 48 09 00 04 05 -> 8 mem_we pulses at addresses 100..107 with data 48,08,00,00,48,09,00,04, each one cycle after its handshake. Then done=1, cpu_hold=0, boot_pc=100, error=0.
- Bad checksum: same frame with CSUM 06 -> all 8 writes occur, then error=1, done=0, cpu_hold=1, boot_pc stays 0.
- Address checks:
  - A5 00 65 00 01 -> ERR after CNT_LO, no mem_we.
  - A5 3F FC 00 02 -> ERR (16380+8>16384).
  - A5 3F FC 00 01 + 4 payload bytes + correct CSUM -> writes 16380..16383, done=1.
- Garbage and reload: 00 FF 5A then a good frame -> the leading bytes are ignored and the load succeeds. A second good frame at 200 re-raises cpu_hold from SYNC until its CSUM; then boot_pc=200.
- Stall and zero count:
  - A good frame with in_valid low 3 cycles between every byte -> identical writes and result.
  - A5 00 00 00 00 00 -> done=1, boot_pc=0, no writes.
- Reset mid-load: assert reset after the 3rd payload byte -> next cycle cpu_hold=1, done=0, error=0, mem_we=0, state IDLE. A following good frame loads correctly.
